aquila_dev_uart: RTL

- Slave-side responder for the Aquila M_DEVICE master port (uncached device segment 0xC000_0000–0xCFFF_FFFF).
- Provides a memory-mapped 8N1 UART with an 8-entry TX FIFO, a 1-entry RX holding register, status flags and a programmable baud divisor.
- Consumes the strobe/addr/rw/byte_enable/data bus.
- Returns a one-cycle data_ready pulse with read data.

---
 rtl/aquila_dev_uart.sv | 312 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/aquila_dev_uart.sv
// Aquila M_DEVICE slave: memory-mapped 8N1 UART with a TX FIFO, a single-entry
// RX holding register, sticky status flags and a programmable baud divisor.
module aquila_dev_uart #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int TX_FIFO_DEPTH = 8,
    parameter int DIV_RESET     = 867
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    S_DEVICE_strobe_i,
    input  logic [ADDR_WIDTH-1:0]   S_DEVICE_addr_i,
    input  logic                    S_DEVICE_rw_i,
    input  logic [DATA_WIDTH/8-1:0] S_DEVICE_byte_enable_i,
    input  logic [DATA_WIDTH-1:0]   S_DEVICE_data_i,
    output logic                    S_DEVICE_data_ready_o,
    output logic [DATA_WIDTH-1:0]   S_DEVICE_data_o,
    output logic                    uart_tx_o,
    input  logic                    uart_rx_i
);
    localparam int PW = $clog2(TX_FIFO_DEPTH);
    localparam logic [1:0] REG_TX = 2'd0, REG_RX = 2'd1, REG_ST = 2'd2, REG_DIV = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

    typedef struct packed {
        logic                  ready;
        logic [DATA_WIDTH-1:0] data;
    } bus_rsp_t;

    // Reset asserts asynchronously but is released in step with clk_i.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) rst_sync <= 2'b00;
        else         rst_sync <= {rst_sync[0], 1'b1};

    assign rst_n = rst_sync[1];

    logic [1:0] reg_sel;
    logic       wr, rd, rd_rx, st_wr;
    logic       unused_bits;

    assign reg_sel = S_DEVICE_addr_i[3:2];
    assign wr      = S_DEVICE_strobe_i & S_DEVICE_rw_i;
    assign rd      = S_DEVICE_strobe_i & ~S_DEVICE_rw_i;
    assign rd_rx   = rd && (reg_sel == REG_RX);
    assign st_wr   = wr && (reg_sel == REG_ST);
    assign unused_bits = ^{S_DEVICE_addr_i[ADDR_WIDTH-1:4], S_DEVICE_addr_i[1:0],
                           S_DEVICE_data_i[DATA_WIDTH-1:16],
                           S_DEVICE_byte_enable_i[DATA_WIDTH/8-1:2]};

    // TX FIFO: pointers carry one extra wrap bit to tell full from empty.
    logic [7:0]  fifo_mem [TX_FIFO_DEPTH];
    logic [PW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full, push_req, push, pop, drop_set;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign push_req   = wr && (reg_sel == REG_TX) && S_DEVICE_byte_enable_i[0];
    assign push       = push_req && (!fifo_full || pop);
    assign drop_set   = push_req && fifo_full && !pop;

    always_ff @(posedge clk_i)
        if (push) fifo_mem[wr_ptr[PW-1:0]] <= S_DEVICE_data_i[7:0];

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    logic [15:0] div_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= 16'(DIV_RESET);
        end else if (wr && (reg_sel == REG_DIV)) begin
            if (S_DEVICE_byte_enable_i[0]) div_q[7:0]  <= S_DEVICE_data_i[7:0];
            if (S_DEVICE_byte_enable_i[1]) div_q[15:8] <= S_DEVICE_data_i[15:8];
        end
    end

    // Transmitter. The divisor is latched per character so a DIV write never
    // stretches or shortens a character already on the wire.
    uart_state_e tx_state, tx_state_d;
    logic [15:0] tx_cnt, tx_cnt_d, tx_div, tx_div_d;
    logic [2:0]  tx_bit, tx_bit_d;
    logic [7:0]  tx_shift, tx_shift_d;
    logic        tx_line, tx_line_d, tx_tick, tx_busy;

    assign tx_tick   = (tx_cnt == tx_div);
    assign tx_busy   = (tx_state != S_IDLE);
    assign uart_tx_o = tx_line;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_div   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_div   <= tx_div_d;
            tx_bit   <= tx_bit_d;
            tx_shift <= tx_shift_d;
            tx_line  <= tx_line_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt + 16'd1;
        tx_div_d   = tx_div;
        tx_bit_d   = tx_bit;
        tx_shift_d = tx_shift;
        pop        = 1'b0;
        case (tx_state)
            S_IDLE: begin
                tx_cnt_d = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    tx_shift_d = fifo_mem[rd_ptr[PW-1:0]];
                    tx_div_d   = div_q;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                if (tx_tick) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tx_tick) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift[7:1]};
                    tx_bit_d   = tx_bit + 3'd1;
                    if (tx_bit == 3'd7) tx_state_d = S_STOP;
                end
            end
            default: begin
                if (tx_tick) begin
                    tx_cnt_d = '0;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        tx_shift_d = fifo_mem[rd_ptr[PW-1:0]];
                        tx_div_d   = div_q;
                        tx_state_d = S_START;
                    end else begin
                        tx_state_d = S_IDLE;
                    end
                end
            end
        endcase
        // Line level follows the next state so the pin comes straight off a flop.
        case (tx_state_d)
            S_START: tx_line_d = 1'b0;
            S_DATA:  tx_line_d = tx_shift_d[0];
            default: tx_line_d = 1'b1;
        endcase
    end

    // Receiver: two-flop synchronizer plus a delayed copy for edge detection.
    logic rx_s1, rx_s2, rx_prev;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx_i;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    uart_state_e rx_state, rx_state_d;
    logic [15:0] rx_cnt, rx_cnt_d, rx_div, rx_div_d;
    logic [2:0]  rx_bit, rx_bit_d;
    logic [7:0]  rx_shift, rx_shift_d;
    logic        rx_done, rx_ferr;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_div   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_d;
            rx_cnt   <= rx_cnt_d;
            rx_div   <= rx_div_d;
            rx_bit   <= rx_bit_d;
            rx_shift <= rx_shift_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state;
        rx_cnt_d   = rx_cnt + 16'd1;
        rx_div_d   = rx_div;
        rx_bit_d   = rx_bit;
        rx_shift_d = rx_shift;
        rx_done    = 1'b0;
        rx_ferr    = 1'b0;
        case (rx_state)
            S_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev && !rx_s2) begin
                    rx_div_d   = div_q;
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                // Half-bit check; every later sample is a full bit apart.
                if (rx_cnt == (rx_div >> 1)) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_cnt == rx_div) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2, rx_shift[7:1]};
                    rx_bit_d   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_d = S_STOP;
                end
            end
            default: begin
                if (rx_cnt == rx_div) begin
                    rx_cnt_d   = '0;
                    rx_state_d = S_IDLE;
                    rx_done    = rx_s2;
                    rx_ferr    = !rx_s2;
                end
            end
        endcase
    end

    // Sticky flags: a set in the same cycle as a clear write wins.
    logic [7:0] rx_byte;
    logic       rx_valid, rx_overrun, rx_frame_err, tx_drop;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rx_byte      <= '0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
            tx_drop      <= 1'b0;
        end else begin
            if (rx_done) rx_byte <= rx_shift;

            if (rx_done)    rx_valid <= 1'b1;
            else if (rd_rx) rx_valid <= 1'b0;

            if (rx_done && rx_valid && !rd_rx)   rx_overrun <= 1'b1;
            else if (st_wr && S_DEVICE_data_i[3]) rx_overrun <= 1'b0;

            if (rx_ferr)                          rx_frame_err <= 1'b1;
            else if (st_wr && S_DEVICE_data_i[4]) rx_frame_err <= 1'b0;

            if (drop_set)                         tx_drop <= 1'b1;
            else if (st_wr && S_DEVICE_data_i[5]) tx_drop <= 1'b0;
        end
    end

    logic [DATA_WIDTH-1:0] rdata;
    bus_rsp_t              rsp_q;

    always_comb begin
        rdata = '0;
        if (rd) begin
            case (reg_sel)
                REG_RX: begin
                    rdata[7:0]            = rx_byte;
                    rdata[DATA_WIDTH-1]   = rx_valid;
                end
                REG_ST:  rdata[6:0]  = {tx_busy, tx_drop, rx_frame_err, rx_overrun,
                                        rx_valid, fifo_empty, fifo_full};
                REG_DIV: rdata[15:0] = div_q;
                default: rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rsp_q <= '0;
        end else begin
            rsp_q.ready <= S_DEVICE_strobe_i;
            rsp_q.data  <= rdata;
        end
    end

    assign S_DEVICE_data_ready_o = rsp_q.ready;
    assign S_DEVICE_data_o       = rsp_q.data;

endmodule
